// File: rtl/mem_pkg.sv
// Shared constants and types for the MESTPro memory master and its memory model.
package mem_pkg;

    localparam int unsigned DefAddrBits = 8;
    localparam int unsigned DefDataBits = 8;
    localparam int unsigned DefRomSize  = 128;
    localparam int unsigned DefMemSize  = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mem_state_e;

    // One-hot grant encoding shared by the arbiter and the FSM.
    localparam int unsigned GntIfBit = 0;
    localparam int unsigned GntDBit  = 1;
    localparam logic [1:0]  GntNone  = 2'b00;
    localparam logic [1:0]  GntIf    = 2'b01;
    localparam logic [1:0]  GntD     = 2'b10;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-port round-robin arbiter; a tie goes to the port that was not granted last.
module mem_rr_arb
    import mem_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_if_i,
    input  logic       req_d_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // Set when the data port received the most recent grant.
    logic last_d_q;

    always_comb begin
        gnt_o = GntNone;
        if (req_if_i && req_d_i) begin
            gnt_o = last_d_q ? GntIf : GntD;
        end else if (req_if_i) begin
            gnt_o = GntIf;
        end else if (req_d_i) begin
            gnt_o = GntD;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_d_q <= 1'b1;
        end else if (update_i && (gnt_o != GntNone)) begin
            last_d_q <= gnt_o[GntDBit];
        end
    end

endmodule

// File: rtl/mem_master.sv
// Arbitrates fetch and data requests onto the synchronous memory port and returns
// registered read data / write error with a one-cycle acknowledge.
module mem_master
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DefAddrBits,
    parameter int unsigned DATA_BITS = DefDataBits,
    parameter int unsigned ROM_SIZE  = DefRomSize,
    parameter int unsigned MEM_SIZE  = DefMemSize
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 if_req_i,
    input  logic [ADDR_BITS-1:0] if_addr_i,
    output logic                 if_ack_o,
    output logic [DATA_BITS-1:0] if_rdata_o,
    output logic                 if_err_o,
    input  logic                 d_req_i,
    input  logic                 d_we_i,
    input  logic [ADDR_BITS-1:0] d_addr_i,
    input  logic [DATA_BITS-1:0] d_wdata_i,
    output logic                 d_ack_o,
    output logic [DATA_BITS-1:0] d_rdata_o,
    output logic                 d_err_o,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DATA_BITS-1:0] mem_wdata_o,
    input  logic [DATA_BITS-1:0] mem_rdata_i,
    input  logic                 mem_error_i,
    output logic                 busy_o
);

    // Write protection lives in the memory; the ROM size only has to be consistent.
    if (ROM_SIZE > MEM_SIZE) begin : g_bad_cfg
        $error("mem_master: ROM_SIZE larger than MEM_SIZE");
    end

    mem_state_e           state_q;
    logic                 gnt_d_q;
    logic                 store_q;
    logic                 err_q;
    logic                 mem_cs_q;
    logic                 mem_we_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [DATA_BITS-1:0] mem_wdata_q;
    logic                 if_ack_q;
    logic [DATA_BITS-1:0] if_rdata_q;
    logic                 if_err_q;
    logic                 d_ack_q;
    logic [DATA_BITS-1:0] d_rdata_q;
    logic                 d_err_q;

    logic [1:0]           gnt;
    logic                 arb_update;
    logic                 sel_d;
    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr;
    logic                 sel_illegal;

    assign arb_update  = (state_q == IDLE);
    assign sel_d       = gnt[GntDBit];
    assign sel_we      = sel_d & d_we_i;
    assign sel_addr    = sel_d ? d_addr_i : if_addr_i;
    assign sel_illegal = (32'(sel_addr) >= MEM_SIZE);

    mem_rr_arb u_arb (
        .CLK      (CLK),
        .RESET    (RESET),
        .req_if_i (if_req_i),
        .req_d_i  (d_req_i),
        .update_i (arb_update),
        .gnt_o    (gnt)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            gnt_d_q     <= 1'b0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt != GntNone) begin
                        gnt_d_q <= sel_d;
                        store_q <= sel_we;
                        if (sel_illegal) begin
                            // Out-of-range access never reaches the memory.
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            mem_cs_q   <= 1'b1;
                            mem_we_q   <= sel_we;
                            mem_addr_q <= sel_addr;
                            if (sel_d) begin
                                mem_wdata_q <= d_wdata_i;
                            end
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_cs_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= CAPTURE;
                end
                CAPTURE: begin
                    if (store_q) begin
                        err_q <= mem_error_i;
                    end else if (gnt_d_q) begin
                        d_rdata_q <= mem_rdata_i;
                    end else begin
                        if_rdata_q <= mem_rdata_i;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (gnt_d_q) begin
                        d_ack_q <= 1'b1;
                        d_err_q <= err_q;
                    end else begin
                        if_ack_q <= 1'b1;
                        if_err_q <= err_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;
    assign mem_cs_o    = mem_cs_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_master.sv
// Randomized bench for mem_master with a behavioural memory and transaction-level model.
module tb_mem_master;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int ROM = 128;
    localparam int MSZ = 200;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_error;
    logic          busy;

    int n_checks = 0;
    int n_fail = 0;
    int cs_cnt = 0;
    int overlap_cnt = 0;
    logic mem_load = 1'b1;

    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];
    bit            last_d;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;

    mem_master #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .ROM_SIZE  (ROM),
        .MEM_SIZE  (MSZ)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ack_o    (if_ack),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_ack_o     (d_ack),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem_cs_o    (mem_cs),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_error_i (mem_error),
        .busy_o      (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 0) return 8'h13;
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous memory: registered read data, ROM writes blocked and flagged.
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else if (mem_cs) begin
            if (mem_we) begin
                if (int'(mem_addr) < ROM) begin
                    mem_error <= 1'b1;
                end else begin
                    mem_arr[mem_addr] <= mem_wdata;
                    mem_error <= 1'b0;
                end
            end else begin
                mem_rdata <= mem_arr[mem_addr];
                mem_error <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (mem_cs) cs_cnt <= cs_cnt + 1;
        if (if_ack && d_ack) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_if_ack"},    32'(if_ack),    0);
        check_eq({pfx, "_if_rdata"},  32'(if_rdata),  0);
        check_eq({pfx, "_if_err"},    32'(if_err),    0);
        check_eq({pfx, "_d_ack"},     32'(d_ack),     0);
        check_eq({pfx, "_d_rdata"},   32'(d_rdata),   0);
        check_eq({pfx, "_d_err"},     32'(d_err),     0);
        check_eq({pfx, "_mem_cs"},    32'(mem_cs),    0);
        check_eq({pfx, "_mem_we"},    32'(mem_we),    0);
        check_eq({pfx, "_mem_addr"},  32'(mem_addr),  0);
        check_eq({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
        check_eq({pfx, "_busy"},      32'(busy),      0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 2) return AW'($urandom_range(MSZ, 255));
        if (r < 5) return AW'($urandom_range(0, ROM - 1));
        return AW'($urandom_range(ROM, MSZ - 1));
    endfunction

    task automatic raise_if(input logic [AW-1:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic raise_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    // Called just after a clock edge with the master idle: the next edge samples.
    task automatic step();
        bit            g_d;
        bit            we;
        bit            ill;
        bit            exp_err;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_rd;
        int            cs0;
        int            lat;
        g_d    = (if_req && d_req) ? !last_d : d_req;
        last_d = g_d;
        a      = g_d ? d_addr : if_addr;
        we     = g_d && d_we;
        ill    = int'(a) >= MSZ;
        cs0    = cs_cnt;
        for (lat = 1; lat <= 12; lat++) begin
            @(posedge CLK);
            #1;
            if (if_ack || d_ack) break;
        end
        check_eq("latency", 32'(lat - 1), ill ? 1 : 3);
        check_eq("ack_port", {30'd0, d_ack, if_ack}, g_d ? 2 : 1);
        check_eq("cs_pulses", 32'(cs_cnt - cs0), ill ? 0 : 1);
        if (!g_d) begin
            exp_rd = ill ? exp_if_rdata : ref_mem[a];
            check_eq("if_rdata", 32'(if_rdata), 32'(exp_rd));
            check_eq("if_err", 32'(if_err), 32'(ill));
            exp_if_rdata = exp_rd;
            if_req = 1'b0;
        end else begin
            if (we) begin
                exp_err = ill || (int'(a) < ROM);
                if (!exp_err) ref_mem[a] = d_wdata;
                exp_rd = exp_d_rdata;
            end else begin
                exp_err = ill;
                exp_rd  = ill ? exp_d_rdata : ref_mem[a];
            end
            check_eq("d_rdata", 32'(d_rdata), 32'(exp_rd));
            check_eq("d_err", 32'(d_err), 32'(exp_err));
            exp_d_rdata = exp_rd;
            d_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nif;
        int nd;
        int acks;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        last_d       = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;

        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        RESET    = 1'b1;
        mem_load = 1'b0;

        // Fetch of the first program word.
        raise_if(8'd0);
        step();
        check_eq("fetch0_word", 32'(if_rdata), 32'h13);

        // RAM store then load back; ROM store blocked.
        raise_d(1'b1, AW'(ROM), 8'hA5);
        step();
        raise_d(1'b0, AW'(ROM), 8'h00);
        step();
        check_eq("ram_readback", 32'(d_rdata), 32'hA5);
        raise_d(1'b1, 8'd3, 8'hFF);
        step();
        check_eq("rom_store_err", 32'(d_err), 1);
        raise_d(1'b0, 8'd3, 8'h00);
        step();
        check_eq("rom_unchanged", 32'(d_rdata), 32'(init_word(3)));

        // Both ports contend; each re-raises right after its own ack.
        raise_if(rand_addr());
        raise_d(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        nif = 1;
        nd  = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!if_req && nif < 4) begin
                raise_if(rand_addr());
                nif++;
            end
            if (!d_req && nd < 4) begin
                raise_d(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
                nd++;
            end
        end

        // Out-of-range fetch.
        raise_if(8'd220);
        step();
        check_eq("illegal_fetch_err", 32'(if_err), 1);

        // Random traffic on both ports.
        for (int i = 0; i < 80; i++) begin
            if (!if_req && $urandom_range(0, 1) == 1) raise_if(rand_addr());
            if (!d_req && $urandom_range(0, 1) == 1)
                raise_d(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if (!if_req && !d_req) raise_if(rand_addr());
            step();
        end
        while (if_req || d_req) step();

        // Reset during the ISSUE cycle of a store.
        raise_d(1'b1, 8'd160, 8'h5A);
        @(posedge CLK);
        #1;
        check_eq("issue_cs", 32'(mem_cs), 1);
        #2;
        RESET = 1'b0;
        #1;
        check_zero_outputs("midreset");
        last_d       = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        acks = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (d_ack || if_ack) acks++;
        end
        check_eq("no_ack_in_reset", 32'(acks), 0);
        RESET = 1'b1;
        step();
        raise_d(1'b0, 8'd160, 8'h00);
        step();
        check_eq("reissued_store", 32'(d_rdata), 32'h5A);

        check_eq("ack_overlap", 32'(overlap_cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
